// File: rtl/fetch_controller.sv
// Fetch-side PC sequencer: picks hold, sequential, branch, jump or exception
// vector for the PC register, tracks redirects deferred by a busy memory.
module fetch_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pcCurrent,
    input  logic                 exception,
    input  logic                 branchTaken,
    input  logic [31:0]          branchTarget,
    input  logic                 jump,
    input  logic [31:0]          jumpTarget,
    input  logic                 stallRequest,
    input  logic                 imemReady,
    output logic [31:0]          pcNext,
    output logic                 pcFlush,
    output logic                 ifIdFlush,
    output logic                 imemRequest,
    output logic [CNT_WIDTH-1:0] stallCount,
    output logic [CNT_WIDTH-1:0] redirectCount
);

    // state    | meaning
    // BOOT     | first cycle after reset, load RESET_VECTOR
    // RUN      | fetching, memory answered last request
    // WAIT_MEM | fetch outstanding, PC held until imemReady
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [1:0] PRIO_JMP = 2'd1;
    localparam logic [1:0] PRIO_BR  = 2'd2;
    localparam logic [1:0] PRIO_EXC = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           state_q, state_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [31:0]          pend_target_q, pend_target_d;
    logic [1:0]           pend_prio_q, pend_prio_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] redir_cnt_q, redir_cnt_d;

    logic        in_valid;
    logic [31:0] in_target;
    logic [1:0]  in_prio;
    logic [31:0] pc_next_int;
    logic        hold_int;
    logic        flush_int;
    logic        req_int;
    logic        applied;

    // Only the strongest simultaneous redirect survives; weaker ones are dropped.
    always_comb begin
        in_valid  = 1'b1;
        in_target = EXC_VECTOR;
        in_prio   = PRIO_EXC;
        if (exception) begin
            in_target = EXC_VECTOR;
            in_prio   = PRIO_EXC;
        end else if (branchTaken) begin
            in_target = branchTarget;
            in_prio   = PRIO_BR;
        end else if (jump) begin
            in_target = jumpTarget;
            in_prio   = PRIO_JMP;
        end else begin
            in_valid  = 1'b0;
            in_prio   = 2'd0;
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_prio_d   = pend_prio_q;
        pc_next_int   = RESET_VECTOR;
        hold_int      = 1'b1;
        flush_int     = 1'b0;
        req_int       = 1'b0;
        applied       = 1'b0;

        case (state_q)
            ST_RUN, ST_WAIT: begin
                req_int = 1'b1;
                if (!imemReady) begin
                    pc_next_int = pcCurrent;
                    hold_int    = 1'b1;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_RUN;
                    if (in_valid) begin
                        pc_next_int = in_target;
                        hold_int    = 1'b0;
                        applied     = 1'b1;
                    end else if (pend_valid_q) begin
                        pc_next_int = pend_target_q;
                        hold_int    = 1'b0;
                        applied     = 1'b1;
                    end else if (stallRequest) begin
                        pc_next_int = pcCurrent;
                        hold_int    = 1'b1;
                    end else begin
                        pc_next_int = pcCurrent + 32'd4;
                        hold_int    = 1'b0;
                    end
                end
                flush_int = applied;
                if (applied) begin
                    pend_valid_d = 1'b0;
                end else if (hold_int && in_valid &&
                             (!pend_valid_q || in_prio >= pend_prio_q)) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = in_target;
                    pend_prio_d   = in_prio;
                end
            end
            default: begin
                pc_next_int = RESET_VECTOR;
                hold_int    = 1'b0;
                flush_int   = 1'b1;
                state_d     = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (hold_int && state_q != ST_BOOT && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (applied && redir_cnt_q != CNT_MAX) begin
            redir_cnt_d = redir_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_BOOT;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0;
            pend_prio_q   <= 2'd0;
            stall_cnt_q   <= '0;
            redir_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_prio_q   <= pend_prio_d;
            stall_cnt_q   <= stall_cnt_d;
            redir_cnt_q   <= redir_cnt_d;
        end
    end

    // Reset must force the PC register's hold immediately, not on the next edge.
    assign pcNext        = reset ? RESET_VECTOR : pc_next_int;
    assign pcFlush       = reset ? 1'b1 : hold_int;
    assign ifIdFlush     = reset ? 1'b1 : flush_int;
    assign imemRequest   = reset ? 1'b0 : req_int;
    assign stallCount    = stall_cnt_q;
    assign redirectCount = redir_cnt_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller with a negedge-capturing PC register model.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pcCurrent;
    logic        exception = 1'b0;
    logic        branchTaken = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jumpTarget = 32'h0;
    logic        stallRequest = 1'b0;
    logic        imemReady = 1'b1;
    logic [31:0] pcNext;
    logic        pcFlush;
    logic        ifIdFlush;
    logic        imemRequest;
    logic [3:0]  stallCount;
    logic [3:0]  redirectCount;

    int total = 0;
    int bad = 0;
    int step_id = 0;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic        hold;
        logic        flush;
        logic        req;
        logic [3:0]  scnt;
        logic [3:0]  rcnt;
    } exp_t;

    exp_t sb[$];

    fetch_controller #(
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0080),
        .CNT_WIDTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pcCurrent    (pcCurrent),
        .exception    (exception),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .jump         (jump),
        .jumpTarget   (jumpTarget),
        .stallRequest (stallRequest),
        .imemReady    (imemReady),
        .pcNext       (pcNext),
        .pcFlush      (pcFlush),
        .ifIdFlush    (ifIdFlush),
        .imemRequest  (imemRequest),
        .stallCount   (stallCount),
        .redirectCount(redirectCount)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!pcFlush) pcCurrent <= pcNext;
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pcNext",        e.id, pcNext,                e.pc);
                chk("pcFlush",       e.id, {31'h0, pcFlush},      {31'h0, e.hold});
                chk("ifIdFlush",     e.id, {31'h0, ifIdFlush},    {31'h0, e.flush});
                chk("imemRequest",   e.id, {31'h0, imemRequest},  {31'h0, e.req});
                chk("stallCount",    e.id, {28'h0, stallCount},   {28'h0, e.scnt});
                chk("redirectCount", e.id, {28'h0, redirectCount}, {28'h0, e.rcnt});
            end
        end
    end

    task automatic step(input logic rs, input logic rdy, input logic ex, input logic br,
                        input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                        input logic st, input logic [31:0] epc, input logic eh,
                        input logic ef, input logic eq, input int es, input int er);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rs;
        imemReady    = rdy;
        exception    = ex;
        branchTaken  = br;
        branchTarget = bt;
        jump         = jp;
        jumpTarget   = jt;
        stallRequest = st;
        step_id++;
        e.id = step_id; e.pc = epc; e.hold = eh; e.flush = ef; e.req = eq;
        e.scnt = 4'(es); e.rcnt = 4'(er);
        sb.push_back(e);
    endtask

    initial begin
        pcCurrent = 32'hDEAD_BEE0;
        #1 reset = 1'b1;
        // rs rdy ex br bt      jp jt            st | pcNext hold flush req S R
        step(1, 1, 0, 0, 0,      0, 0,            0,  32'h0,   1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h0,   0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h4,   0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h8,   0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'hC,   0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h10,  0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 32'h40, 0, 0,            0,  32'h40,  0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0,      1, 32'h20,       0,  32'h20,  0, 1, 1, 0, 1);
        // memory busy three cycles, jump arrives in the second
        step(0, 0, 0, 0, 0,      0, 0,            0,  32'h20,  1, 0, 1, 0, 2);
        step(0, 0, 0, 0, 0,      1, 32'h100,      0,  32'h20,  1, 0, 1, 1, 2);
        step(0, 0, 0, 0, 0,      0, 0,            0,  32'h20,  1, 0, 1, 2, 2);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h100, 0, 1, 1, 3, 2);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h104, 0, 0, 1, 3, 3);
        // exception beats branch, branch not pended
        step(0, 1, 1, 1, 32'h40, 0, 0,            0,  32'h80,  0, 1, 1, 3, 3);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h84,  0, 0, 1, 3, 4);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h88,  0, 0, 1, 3, 4);
        // pended exception not overwritten by a later jump
        step(0, 0, 1, 0, 0,      0, 0,            0,  32'h88,  1, 0, 1, 3, 4);
        step(0, 0, 0, 0, 0,      1, 32'h200,      0,  32'h88,  1, 0, 1, 4, 4);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h80,  0, 1, 1, 5, 4);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h84,  0, 0, 1, 5, 5);
        // load-use stall at 0x30
        step(0, 1, 0, 0, 0,      1, 32'h30,       0,  32'h30,  0, 1, 1, 5, 5);
        step(0, 1, 0, 0, 0,      0, 0,            1,  32'h30,  1, 0, 1, 5, 6);
        step(0, 1, 0, 0, 0,      0, 0,            1,  32'h30,  1, 0, 1, 6, 6);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h34,  0, 0, 1, 7, 6);
        step(0, 1, 0, 0, 0,      1, 32'h30,       0,  32'h30,  0, 1, 1, 7, 6);
        step(0, 1, 0, 1, 32'h50, 0, 0,            1,  32'h50,  0, 1, 1, 7, 7);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h54,  0, 0, 1, 7, 8);
        // sequential wrap at the top of the address space
        step(0, 1, 0, 0, 0,      1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 1, 1, 7, 8);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h0,   0, 0, 1, 7, 9);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h4,   0, 0, 1, 7, 9);
        // reset during WAIT_MEM with a branch pending
        step(0, 0, 0, 0, 0,      0, 0,            0,  32'h4,   1, 0, 1, 7, 9);
        step(0, 0, 0, 1, 32'h300, 0, 0,           0,  32'h4,   1, 0, 1, 8, 9);
        step(1, 0, 0, 0, 0,      0, 0,            0,  32'h0,   1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h0,   0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h4,   0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h8,   0, 0, 1, 0, 0);
        // counter saturation (4-bit counters)
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 0, 1, (i > 15) ? 15 : i, 0);
        for (int i = 0; i < 18; i++)
            step(0, 1, 0, 0, 0, 1, 32'h40, 0, 32'h40, 0, 1, 1, 15, (i > 15) ? 15 : i);
        step(0, 1, 0, 0, 0,      0, 0,            0,  32'h44,  0, 0, 1, 15, 15);

        repeat (3) @(posedge clk);
        #5;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
